// File: rtl/bambu_mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, fixed-latency RAM between two Bambu bus channels.
// Optional BAMBU_MEM_ARB_PERF_EN adds saturating grant and conflict counters.
module bambu_mem_port_arbiter #(
  parameter int BITSIZE_addr = 7,
  parameter int BITSIZE_data = 8,
  parameter int BITSIZE_size = 4,
  parameter int READ_LAT     = 2,
  parameter int WRITE_LAT    = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                Mout_oe_ram,
  input  logic [1:0]                Mout_we_ram,
  input  logic [2*BITSIZE_addr-1:0] Mout_addr_ram,
  input  logic [2*BITSIZE_data-1:0] Mout_Wdata_ram,
  input  logic [2*BITSIZE_size-1:0] Mout_data_ram_size,
  output logic [2*BITSIZE_data-1:0] M_Rdata_ram,
  output logic [1:0]                M_DataRdy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [BITSIZE_addr-1:0]   mem_addr,
  output logic [BITSIZE_data-1:0]   mem_wdata,
  output logic [BITSIZE_data-1:0]   mem_wmask,
  input  logic [BITSIZE_data-1:0]   mem_rdata,
`ifdef BAMBU_MEM_ARB_PERF_EN
  output logic [31:0]               grant_cnt0,
  output logic [31:0]               grant_cnt1,
  output logic [31:0]               conflict_cnt,
`endif
  output logic                      proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    last_grant;
  logic                    grant_q;
  logic                    we_q;
  logic [BITSIZE_addr-1:0] addr_q;
  logic [BITSIZE_data-1:0] wdata_q;
  logic [BITSIZE_size-1:0] size_q;
  logic [BITSIZE_data-1:0] rdata_q;
  logic [BITSIZE_data-1:0] mask;
  logic [1:0]              valid;
  logic                    grant;
  logic                    lat_done;

  // A channel requests only when exactly one of oe/we is set; both set is a protocol error.
  assign valid = Mout_oe_ram ^ Mout_we_ram;

  always_comb begin
    if (valid == 2'b11) grant = ~last_grant;
    else                grant = valid[1];
  end

  assign lat_done = we_q ? (wait_cnt == CNT_W'(WRITE_LAT - 1))
                         : (wait_cnt == CNT_W'(READ_LAT - 1));

  // Bit i of the mask is set when i < size, so size 0 gives 0 and size >= width gives all ones.
  always_comb begin
    mask = '0;
    for (int i = 0; i < BITSIZE_data; i++) mask[i] = (i < int'(size_q));
  end

  // NOTE: every output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    M_DataRdy   = 2'b00;
    M_Rdata_ram = '0;
    case (state)
      IDLE: if (|valid) state_nxt = ISSUE;
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = mask;
        state_nxt = WAIT;
      end
      WAIT: if (lat_done) state_nxt = RESP;
      RESP: begin
        M_DataRdy = grant_q ? 2'b10 : 2'b01;
        if (!we_q) begin
          if (grant_q) M_Rdata_ram[2*BITSIZE_data-1:BITSIZE_data] = rdata_q & mask;
          else         M_Rdata_ram[BITSIZE_data-1:0]              = rdata_q & mask;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  // NOTE: the latched request is reset too, so a reset mid-access leaves no stale operation behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      rdata_q    <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|(Mout_oe_ram & Mout_we_ram)) proto_err <= 1'b1;
          if (|valid) begin
            grant_q    <= grant;
            last_grant <= grant;
            we_q       <= grant ? Mout_we_ram[1] : Mout_we_ram[0];
            addr_q     <= grant ? Mout_addr_ram[2*BITSIZE_addr-1:BITSIZE_addr]
                                : Mout_addr_ram[BITSIZE_addr-1:0];
            wdata_q    <= grant ? Mout_Wdata_ram[2*BITSIZE_data-1:BITSIZE_data]
                                : Mout_Wdata_ram[BITSIZE_data-1:0];
            size_q     <= grant ? Mout_data_ram_size[2*BITSIZE_size-1:BITSIZE_size]
                                : Mout_data_ram_size[BITSIZE_size-1:0];
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (lat_done && !we_q) rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef BAMBU_MEM_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else if (state == IDLE) begin
      if (|valid && !grant && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (|valid &&  grant && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 32'd1;
      if (valid == 2'b11 && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
